divider_arbiter: RTL
====================

Name: divider_arbiter

Overview:
Shares one sequential `divider` instance (start/valid handshake, `zeroErr`, optional result caching) among N requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Pulses the divider's `start`, waits for its `valid`, then returns quotient, remainder and error flags to the winner with a one-cycle `done` pulse.
- Sits between client blocks and the divider datapath; it is the divider's only driver.

Parameters:
- WIDTH, 32, operand/result width; must match the attached divider.
- N, 4, number of requesters (2..16).
- TIMEOUT, 96, max cycles spent in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  per-requester request; held high with operands stable until that requester's `done`.
- dividendIn  in  N*WIDTH  packed dividends; requester i occupies bits [i*WIDTH +: WIDTH].
- divisorIn  in  N*WIDTH  packed divisors, same packing.
- done  out  N  one-hot, one-cycle pulse to the served requester.
- quotientOut  out  WIDTH  result; valid while `done` is high, held until the next `done`.
- remainderOut  out  WIDTH  result; same timing as quotientOut.
- zeroErrOut  out  1  divider reported divide-by-zero; qualified by `done`.
- timeoutErr  out  1  operation aborted by timeout; qualified by `done`.
- busy  out  1  high in every state except IDLE.
- divStart  out  1  to divider `start`.
- divDividend  out  WIDTH  to divider `dividend`; registered, stable from START through DONE.
- divDivisor  out  WIDTH  to divider `divisor`; registered, stable from START through DONE.
- divQuotient  in  WIDTH  from divider.
- divRemainder  in  WIDTH  from divider.
- divZeroErr  in  1  from divider.
- divValid  in  1  from divider.

Behaviour:
- Reset (synchronous, overrides everything):
  - state=IDLE; all outputs 0.
  - Priority pointer `last`=N-1, so requester 0 has highest priority after reset.
- Reset mid-operation: abandon the operation with no `done` pulse; `busy`=0 the next cycle. The divider shares `rst`.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If any `req` bit is set, pick the first set bit scanning `last+1, last+2, …` modulo N.
  - Latch winner index into `idx`, and its operands into divDividend/divDivisor; go to START.
- START: `divStart`=1 for exactly one cycle; reset the timeout counter; go to WAIT.
- WAIT:
  - Divider contract: `divValid` is low in the first cycle after `start` is sampled unless the result was cached. A cache hit keeps it high.
  - Any cycle in WAIT with `divValid`=1: latch divQuotient, divRemainder and divZeroErr into the outputs, clear `timeoutErr`, go to DONE.
  - Counter reaches TIMEOUT (when TIMEOUT≠0): set `timeoutErr`=1, `zeroErrOut`=0, leave quotient/remainder unchanged, go to DONE.
  - If `divValid` and the timeout coincide, `divValid` wins.
- DONE: `done[idx]`=1 for one cycle; `last`=idx; go to IDLE.
- Latency:
  - `req` seen in IDLE at cycle t → `divStart` at t+1 → WAIT from t+2.
  - `done` asserts the cycle after `divValid` is sampled in WAIT.
  - Minimum grant-to-done latency is 3 cycles (cache hit).
- Back-to-back requests:
  - A requester must drop `req` the cycle after `done`.
  - If `req` is still high when the FSM returns to IDLE, it counts as a new request.
  - Because `last` moved, any other pending requester is served first.
- Fairness: a continuously asserted request is served within N operations.
- `req` changes while busy are ignored; only IDLE samples `req`.
- Requests with `divisor`=0 are forwarded unchanged; the divider's `zeroErr` is passed through.
- No arithmetic is performed in this block.

Test Plan (N=4, WIDTH=32, real divider with CACHING=1 plus a stall model where noted):
1. req[0] with 12344235/2343 → exactly one `done[0]` pulse; quotientOut=5268, remainderOut=1311, zeroErrOut=0; `busy` high from grant until after `done`.
2. req=4'b1111 in one cycle, all divisors 7, dividends 70/71/72/73 → `done` order 0,1,2,3; quotients 10 each; remainders 0,1,2,3. Then req={3,0} simultaneously → order 0, then 3.
3. req[2] with 4624653/0 → `done[2]` with zeroErrOut=1 and timeoutErr=0.
4. req[1] with 59049/3 twice back-to-back (second is a cache hit) → both `done[1]` show quotient 19683, remainder 0; second grant-to-done latency ≥3 cycles; exactly one `divStart` pulse per operation.
5. Stall model holding `divValid` low, TIMEOUT=16 → `done[0]` exactly 16 cycles after entering WAIT, with timeoutErr=1. Repeat with `divValid` rising on the 16th cycle → timeoutErr=0 and results latched.
6. Assert `rst` during WAIT of a req[3] operation → no `done`; `busy`=0 the next cycle. With req[3] and req[1] pending after reset, requester 1 is served first (`last` is back to 3).

Source files
------------

// File: rtl/divider_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : divider_arbiter
// Purpose : Round-robin sharing of one sequential divider among N requesters.
// Revision: 1.0 - initial release
// ============================================================================
module divider_arbiter #(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int TIMEOUT = 96
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] dividendIn,
  input  logic [N*WIDTH-1:0] divisorIn,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   quotientOut,
  output logic [WIDTH-1:0]   remainderOut,
  output logic               zeroErrOut,
  output logic               timeoutErr,
  output logic               busy,
  output logic               divStart,
  output logic [WIDTH-1:0]   divDividend,
  output logic [WIDTH-1:0]   divDivisor,
  input  logic [WIDTH-1:0]   divQuotient,
  input  logic [WIDTH-1:0]   divRemainder,
  input  logic               divZeroErr,
  input  logic               divValid
);

  localparam int          c_IW      = (N > 1) ? $clog2(N) : 1;
  localparam bit          c_TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [c_IW-1:0]  r_idx;
  logic [c_IW-1:0]  r_last;
  logic [31:0]      r_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_zero;
  logic             r_tout;

  logic             w_any;
  logic [c_IW-1:0]  w_win;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;

  // Scan starts just after the last served requester, wrapping modulo N.
  always_comb begin
    int j;
    w_any = 1'b0;
    w_win = '0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = int'(r_last) + k;
      if (j >= N) j = j - N;
      if (!w_any && req[c_IW'(j)]) begin
        w_any = 1'b1;
        w_win = c_IW'(j);
      end
    end
  end

  assign w_op_a = dividendIn[int'(w_win)*WIDTH +: WIDTH];
  assign w_op_b = divisorIn[int'(w_win)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_idx      <= '0;
      r_last     <= c_IW'(N - 1);
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_zero     <= 1'b0;
      r_tout     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_idx      <= w_win;
            r_dividend <= w_op_a;
            r_divisor  <= w_op_b;
            r_state    <= c_START;
          end
        end
        c_START: begin
          r_cnt   <= '0;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          // A result arriving in the final allowed cycle beats the timeout.
          if (divValid) begin
            r_quot  <= divQuotient;
            r_rem   <= divRemainder;
            r_zero  <= divZeroErr;
            r_tout  <= 1'b0;
            r_state <= c_DONE;
          end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
            r_zero  <= 1'b0;
            r_tout  <= 1'b1;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        c_DONE: begin
          r_last  <= r_idx;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign done         = (r_state == c_DONE) ? (N'(1) << r_idx) : '0;
  assign busy         = (r_state != c_IDLE);
  assign divStart     = (r_state == c_START);
  assign divDividend  = r_dividend;
  assign divDivisor   = r_divisor;
  assign quotientOut  = r_quot;
  assign remainderOut = r_rem;
  assign zeroErrOut   = r_zero;
  assign timeoutErr   = r_tout;

endmodule
`default_nettype wire
